rec_player: RTL and testbench

Playback engine for recorded melodies: reads note entries (octave, note, length) sequentially from the record memory written during study mode and drives the buzzer with the matching square-wave tone for the recorded duration. It is the read-side counterpart of the recording path, sitting between the record RAM and the buzzer/LED/tube outputs in the top-level mode mux. It supports pause, stop, single-shot or looped playback, and exposes the current note for display.

---
 rtl/rec_player.sv | 241 ++++++++++++++++++++++++
 tb/tb_rec_player.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_player.sv
`default_nettype none
// ============================================================================
//  Module   : rec_player
//  Purpose  : Plays back recorded note entries from the record RAM as
//             square-wave buzzer tones, with pause, stop and loop support.
//  Revision : 1.0  initial release
// ============================================================================
module rec_player #(
    parameter int unsigned UNIT_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_000_000,
    parameter int unsigned TONE_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    input  logic [5:0] rec_len,
    output logic       rd_en,
    output logic [5:0] rd_addr,
    input  logic [2:0] rd_octave,
    input  logic [2:0] rd_note,
    input  logic [1:0] rd_length,
    output logic [2:0] cur_octave,
    output logic [2:0] cur_note,
    output logic [1:0] cur_length,
    output logic       note_active,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(8 * UNIT_TICKS + 1);
    localparam int TONE_W = 21;

    // Sounding part of each note; the last GAP_TICKS of every length are silent.
    localparam logic [CNT_W-1:0] c_dur_l0 = CNT_W'(1 * UNIT_TICKS - GAP_TICKS);
    localparam logic [CNT_W-1:0] c_dur_l1 = CNT_W'(2 * UNIT_TICKS - GAP_TICKS);
    localparam logic [CNT_W-1:0] c_dur_l2 = CNT_W'(4 * UNIT_TICKS - GAP_TICKS);
    localparam logic [CNT_W-1:0] c_dur_l3 = CNT_W'(8 * UNIT_TICKS - GAP_TICKS);
    localparam logic [CNT_W-1:0] c_gap    = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic [5:0]        len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic              buzz_q, buzz_d;
    logic              done_q, done_d;
    logic [2:0]        cur_octave_q, cur_octave_d;
    logic [2:0]        cur_note_q, cur_note_d;
    logic [1:0]        cur_length_q, cur_length_d;

    logic [CNT_W-1:0]  w_dur_load;
    logic [TONE_W-1:0] w_base;
    logic [TONE_W-1:0] w_scaled;
    logic [TONE_W-1:0] w_half;
    logic              w_sounding;
    logic              w_last;

    always_comb begin
        case (rd_length)
            2'd0:    w_dur_load = c_dur_l0;
            2'd1:    w_dur_load = c_dur_l1;
            2'd2:    w_dur_load = c_dur_l2;
            default: w_dur_load = c_dur_l3;
        endcase
    end

    // Octave-4 half periods, scaled by octave then by the speed-up shift.
    always_comb begin
        case (cur_note_q)
            3'd1:    w_base = 21'd191110;
            3'd2:    w_base = 21'd170262;
            3'd3:    w_base = 21'd151685;
            3'd4:    w_base = 21'd143172;
            3'd5:    w_base = 21'd127551;
            3'd6:    w_base = 21'd113636;
            3'd7:    w_base = 21'd101239;
            default: w_base = 21'd0;
        endcase
        if (cur_octave_q < 3'd4) begin
            w_scaled = w_base << (3'd4 - cur_octave_q);
        end else begin
            w_scaled = w_base >> (cur_octave_q - 3'd4);
        end
        w_half = w_scaled >> TONE_SHIFT;
        if (w_half == '0) begin
            w_half = 21'd1;
        end
    end

    assign w_sounding = (cur_note_q != 3'd0) && (cur_octave_q != 3'd0);
    assign w_last     = (addr_q >= len_q - 6'd1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        tone_d       = tone_q;
        buzz_d       = buzz_q;
        done_d       = 1'b0;
        cur_octave_d = cur_octave_q;
        cur_note_d   = cur_note_q;
        cur_length_d = cur_length_q;

        case (state_q)
            S_IDLE: begin
                buzz_d = 1'b0;
                if (start) begin
                    len_d  = rec_len;
                    addr_d = 6'd0;
                    if (rec_len == 6'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                cur_octave_d = rd_octave;
                cur_note_d   = rd_note;
                cur_length_d = rd_length;
                cnt_d        = w_dur_load;
                tone_d       = '0;
                buzz_d       = 1'b0;
                state_d      = S_PLAY;
            end
            S_PLAY: begin
                if (pause) begin
                    // Counters hold; the tone resumes low after release.
                    buzz_d = 1'b0;
                end else begin
                    if (w_sounding) begin
                        if (tone_q == w_half - 21'd1) begin
                            tone_d = '0;
                            buzz_d = ~buzz_q;
                        end else begin
                            tone_d = tone_q + 21'd1;
                        end
                    end else begin
                        buzz_d = 1'b0;
                    end
                    if (cnt_q == c_one) begin
                        cnt_d   = c_gap;
                        buzz_d  = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - c_one;
                    end
                end
            end
            S_GAP: begin
                buzz_d = 1'b0;
                if (!pause) begin
                    if (cnt_q == c_one) begin
                        if (!w_last) begin
                            addr_d  = addr_q + 6'd1;
                            state_d = S_FETCH;
                        end else if (loop) begin
                            addr_d  = 6'd0;
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - c_one;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything else and keeps the last note on display.
        if (stop) begin
            state_d      = S_IDLE;
            addr_d       = addr_q;
            len_d        = len_q;
            buzz_d       = 1'b0;
            done_d       = 1'b0;
            cur_octave_d = cur_octave_q;
            cur_note_d   = cur_note_q;
            cur_length_d = cur_length_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            tone_q       <= '0;
            buzz_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_octave_q <= '0;
            cur_note_q   <= '0;
            cur_length_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            tone_q       <= tone_d;
            buzz_q       <= buzz_d;
            done_q       <= done_d;
            cur_octave_q <= cur_octave_d;
            cur_note_q   <= cur_note_d;
            cur_length_q <= cur_length_d;
        end
    end

    assign rd_en       = (state_q == S_FETCH);
    assign rd_addr     = addr_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign note_active = (state_q == S_PLAY) && w_sounding;
    assign buzzer      = buzz_q && (state_q == S_PLAY) && !pause;
    assign cur_octave  = cur_octave_q;
    assign cur_note    = cur_note_q;
    assign cur_length  = cur_length_q;

endmodule
`default_nettype wire

// File: tb/tb_rec_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rec_player
//  Purpose  : Randomized and directed playback scenarios for rec_player,
//             compared cycle by cycle against a timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rec_player;

    localparam int UNIT  = 20;
    localparam int GAP   = 4;
    localparam int SHIFT = 14;
    localparam int BASE [7] = '{191110, 170262, 151685, 143172, 127551, 113636, 101239};

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, loop;
    logic [5:0] rec_len;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [2:0] rd_octave, rd_note;
    logic [1:0] rd_length;
    logic [2:0] cur_octave, cur_note;
    logic [1:0] cur_length;
    logic       note_active, buzzer, busy, done;

    logic [7:0] mem [64];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        bit rd_en; int addr; bit busy; bit buzz; bit done;
        bit na; bit na_chk; bit cur_chk; int co; int cn; int cl;
    } exp_t;
    exp_t tr[$];

    rec_player #(.UNIT_TICKS(UNIT), .GAP_TICKS(GAP), .TONE_SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop(loop), .rec_len(rec_len), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_octave(rd_octave), .rd_note(rd_note), .rd_length(rd_length),
        .cur_octave(cur_octave), .cur_note(cur_note), .cur_length(cur_length),
        .note_active(note_active), .buzzer(buzzer), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Record RAM: one-cycle read latency, garbage on the bus otherwise.
    always @(posedge clk) begin
        if (rd_en) {rd_octave, rd_note, rd_length} <= mem[rd_addr];
        else       {rd_octave, rd_note, rd_length} <= 8'($urandom);
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int half_of(input int oct, input int nt);
        int h;
        if (nt == 0 || oct == 0) return 1;
        if (oct < 4) h = BASE[nt-1] * (2 ** (4 - oct));
        else         h = BASE[nt-1] / (2 ** (oct - 4));
        h = h / (2 ** SHIFT);
        return (h < 1) ? 1 : h;
    endfunction

    // Expected per-cycle outputs from the start cycle onward.
    task automatic build(input int len, input bit lp, input int nent, input int p_ent,
                         input int p_j, input int p_len, output int p_lo);
        exp_t e;
        int idx, oct, nt, lk, half, plen;
        bit snd, b;
        tr.delete();
        p_lo = -1;
        e = '{default: 0};
        tr.push_back(e);
        if (len == 0) begin
            e.done = 1; tr.push_back(e);
            e.done = 0; tr.push_back(e);
            return;
        end
        for (int n = 0; n < nent; n++) begin
            idx = n % len;
            oct = int'(mem[idx][7:5]);
            nt  = int'(mem[idx][4:2]);
            lk  = int'(mem[idx][1:0]);
            e = '{default: 0};
            e.busy = 1; e.addr = idx; e.na_chk = 1;
            e.rd_en = 1; tr.push_back(e);
            e.rd_en = 0; tr.push_back(e);
            half = half_of(oct, nt);
            snd  = (oct != 0) && (nt != 0);
            plen = UNIT * (1 << lk) - GAP;
            b = 0;
            e.cur_chk = 1; e.co = oct; e.cn = nt; e.cl = lk;
            for (int j = 0; j < plen; j++) begin
                if (n == p_ent && j == p_j) begin
                    p_lo = tr.size();
                    e.buzz = 0; e.na_chk = 0;
                    repeat (p_len) tr.push_back(e);
                    b = 0;
                end
                e.buzz = snd & b; e.na = snd; e.na_chk = 1;
                tr.push_back(e);
                if (j % half == half - 1) b = ~b;
            end
            e.buzz = 0; e.na = 0;
            repeat (GAP) tr.push_back(e);
        end
        if (!lp) begin
            e = '{default: 0};
            e.done = 1; tr.push_back(e);
            e.done = 0; tr.push_back(e);
        end
    endtask

    // Abort at cycle 'at': idle from the next cycle with the note still shown.
    task automatic apply_stop(input int at);
        exp_t e;
        e = tr[at];
        while (tr.size() > at + 1) tr.delete(tr.size() - 1);
        e.busy = 0; e.rd_en = 0; e.buzz = 0; e.done = 0; e.na = 0; e.na_chk = 1;
        tr.push_back(e);
        tr.push_back(e);
    endtask

    task automatic apply_rst(input int at);
        exp_t e;
        while (tr.size() > at + 1) tr.delete(tr.size() - 1);
        e = '{default: 0};
        e.na_chk = 1; e.cur_chk = 1;
        tr.push_back(e);
        tr.push_back(e);
    endtask

    task automatic run_trace(input int len, input bit lp, input int p_lo, input int p_len,
                             input int stop_at, input int xs, input int rst_at);
        exp_t e;
        for (int c = 0; c < tr.size(); c++) begin
            start   = (c == 0) || (c == xs);
            rec_len = (c == 0) ? 6'(len) : 6'($urandom);
            loop    = lp;
            pause   = (p_lo >= 0) && (c >= p_lo) && (c < p_lo + p_len);
            stop    = (c == stop_at);
            rst     = (c == rst_at);
            cyc     = c;
            @(negedge clk);
            e = tr[c];
            chk_eq("busy",   32'(busy),   32'(e.busy));
            chk_eq("rd_en",  32'(rd_en),  32'(e.rd_en));
            chk_eq("done",   32'(done),   32'(e.done));
            chk_eq("buzzer", 32'(buzzer), 32'(e.buzz));
            if (e.busy)    chk_eq("rd_addr", 32'(rd_addr), 32'(e.addr));
            if (e.na_chk)  chk_eq("note_active", 32'(note_active), 32'(e.na));
            if (e.cur_chk) begin
                chk_eq("cur_octave", 32'(cur_octave), 32'(e.co));
                chk_eq("cur_note",   32'(cur_note),   32'(e.cn));
                chk_eq("cur_length", 32'(cur_length), 32'(e.cl));
            end
            @(posedge clk);
            #1;
        end
        {start, stop, pause, loop, rst} = '0;
        rec_len = '0;
    endtask

    initial begin
        int plo, len, pe, pj, pl, sa, xs, c;
        bit lp;
        {start, stop, pause, loop} = '0;
        rec_len = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_busy",   32'(busy), 0);
        chk_eq("rst_buzzer", 32'(buzzer), 0);
        chk_eq("rst_rd_en",  32'(rd_en), 0);
        chk_eq("rst_done",   32'(done), 0);
        chk_eq("rst_rd_addr", 32'(rd_addr), 0);
        chk_eq("rst_cur", 32'({cur_octave, cur_note, cur_length}), 0);
        @(posedge clk);
        #1;

        // Single note, octave 4 do, one unit.
        mem[0] = {3'd4, 3'd1, 2'd0};
        build(1, 0, 1, -1, 0, 0, plo);
        run_trace(1, 0, plo, 0, -1, -1, -1);

        // Three entries with a rest, plus a start pulse while busy.
        mem[0] = {3'd4, 3'd1, 2'd0}; mem[1] = {3'd0, 3'd0, 2'd1}; mem[2] = {3'd5, 3'd2, 2'd0};
        build(3, 0, 3, -1, 0, 0, plo);
        run_trace(3, 0, plo, 0, -1, 10, -1);

        // Looping two entries, stopped in the third note.
        mem[0] = {3'd3, 3'd5, 2'd0}; mem[1] = {3'd6, 3'd6, 2'd1};
        build(2, 1, 3, -1, 0, 0, plo);
        sa = tr.size() - GAP - 3;
        apply_stop(sa);
        run_trace(2, 1, plo, 0, sa, -1, -1);

        // Pause held ten cycles mid-note.
        mem[0] = {3'd4, 3'd1, 2'd0};
        build(1, 0, 1, 0, 5, 10, plo);
        run_trace(1, 0, plo, 10, -1, -1, -1);

        // Empty recording.
        build(0, 0, 0, -1, 0, 0, plo);
        run_trace(0, 0, plo, 0, -1, -1, -1);

        // Start and stop together from idle.
        build(1, 0, 1, -1, 0, 0, plo);
        apply_stop(0);
        run_trace(1, 0, plo, 0, 0, -1, -1);

        // Reset in the middle of the gap.
        mem[0] = {3'd5, 3'd3, 2'd0};
        build(1, 0, 1, -1, 0, 0, plo);
        apply_rst(20);
        run_trace(1, 0, plo, 0, -1, -1, 20);
        @(negedge clk);
        chk_eq("rst_gap_rd_addr", 32'(rd_addr), 0);
        @(posedge clk);
        #1;

        // Highest tone: half period clamps to one cycle.
        mem[0] = {3'd7, 3'd7, 2'd0};
        build(1, 0, 1, -1, 0, 0, plo);
        run_trace(1, 0, plo, 0, -1, -1, -1);

        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            len = 1 + int'($urandom % 4);
            lp  = 1'($urandom);
            pe  = int'($urandom % len);
            pj  = int'($urandom % (UNIT * (1 << mem[pe][1:0]) - GAP));
            pl  = ($urandom % 2 == 0) ? 0 : 1 + int'($urandom % 12);
            if (pl == 0) pe = -1;
            build(len, lp, lp ? len + 1 : len, pe, pj, pl, plo);
            sa = -1;
            if (lp) begin
                sa = tr.size() - GAP - 3;
                apply_stop(sa);
            end
            c  = 2 + int'($urandom % (tr.size() - 4));
            xs = (tr[c].busy && (sa < 0 || c < sa)) ? c : -1;
            run_trace(len, lp, plo, pl, sa, xs, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
